// File: rtl/read_axi_pkg.sv
// Shared constants and types for the sample read path.
// Sample width, default buffer/frame sizes and a counter-width helper.
package read_axi_pkg;

    localparam int SAMPLE_W      = 14;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_FRAME_LEN = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_rd.sv
// Single-clock FIFO with occupancy count, full and empty flags.
// Pointers wrap naturally; the separate count disambiguates full/empty.
module sync_fifo_rd
    import read_axi_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_rd,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_wr & ~o_full;
    assign w_rd    = i_rd & ~o_empty;
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/read_axi.sv
// Buffers captured samples and drains them as a framed AXI4-Stream.
// Sticky overflow flags samples lost to downstream back-pressure.
module read_axi
    import read_axi_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                   clock_50,
    input  logic                   reset_n,
    input  logic                   sample_valid,
    input  logic [DATA_W-1:0]      sample_data,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int CW = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_hs;
    logic              w_load;
    logic              w_drop;
    logic [CW-1:0]     w_beat_nxt;

    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_ovf;
    logic [CW-1:0]     r_beat;

    sync_fifo_rd #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock_50),
        .rst_n   (reset_n),
        .i_wr    (sample_valid),
        .i_wdata (sample_data),
        .i_rd    (w_load),
        .o_rdata (w_head),
        .o_count (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_hs   = r_tvalid & m_axis_tready;
    assign w_load = ~w_empty & (~r_tvalid | m_axis_tready);
    assign w_drop = sample_valid & w_full;

    // Beat index of the word that would be loaded this cycle.
    always_comb begin
        w_beat_nxt = r_beat;
        if (w_hs) begin
            w_beat_nxt = (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_beat   <= '0;
        end else begin
            r_beat <= w_beat_nxt;
            if (w_load) begin
                r_tdata  <= w_head;
                r_tvalid <= 1'b1;
                r_tlast  <= (w_beat_nxt == LAST_BEAT);
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clear_overflow) begin
            r_ovf <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_read_axi.sv
// Directed bench for read_axi: latency, back-pressure, overflow,
// framing under random stalls and asynchronous reset mid-frame.
module tb_read_axi;
    import read_axi_pkg::*;

    localparam int DEPTH = 16;
    localparam int FL    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock_50       = 1'b0;
    logic          reset_n        = 1'b0;
    logic          sample_valid   = 1'b0;
    sample_t       sample_data    = '0;
    logic          m_axis_tready  = 1'b0;
    logic          clear_overflow = 1'b0;
    sample_t       m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    wire [31:0] x_data  = 32'(m_axis_tdata);
    wire [31:0] x_valid = 32'(m_axis_tvalid);
    wire [31:0] x_last  = 32'(m_axis_tlast);
    wire [31:0] x_ovf   = 32'(overflow);
    wire [31:0] x_level = 32'(fifo_level);

    int n_chk  = 0;
    int n_pass = 0;
    int bc     = 0;

    read_axi #(
        .DATA_W    (SAMPLE_W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FL)
    ) dut (
        .clock_50       (clock_50),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .fifo_level     (fifo_level)
    );

    always #5 clock_50 = ~clock_50;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    // Checks a beat that completes at the next edge (tready already 1).
    task automatic beat(input int exp_d);
        chk("beat_valid", x_valid, 1);
        chk("beat_data", x_data, exp_d);
        chk("beat_last", x_last, (bc == FL - 1) ? 1 : 0);
        bc = (bc + 1) % FL;
    endtask

    initial begin
        int q[$];
        int sent;
        int beats;
        int lasts;
        int e;

        // reset values
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", x_valid, 0);
        chk("rst_data", x_data, 0);
        chk("rst_last", x_last, 0);
        chk("rst_ovf", x_ovf, 0);
        chk("rst_level", x_level, 0);
        reset_n = 1'b1;
        repeat (6) tick();

        // latency: strobe in N, tvalid in N+2 only
        sample_valid = 1'b1;
        sample_data  = sample_t'(32'h1ABC);
        tick();
        sample_valid = 1'b0;
        chk("lat_n1_valid", x_valid, 0);
        chk("lat_n1_level", x_level, 1);
        tick();
        beat(32'h1ABC);
        chk("lat_n2_level", x_level, 0);
        tick();
        chk("lat_n3_valid", x_valid, 0);

        // back-pressure hold
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'(i);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        chk("bp_valid", x_valid, 1);
        chk("bp_data", x_data, 1);
        chk("bp_level", x_level, 2);
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            beat(i);
            tick();
        end
        chk("bp_end_valid", x_valid, 0);
        chk("bp_end_level", x_level, 0);

        // overflow: 20 strobes, first 17 kept
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'(32'h100 + i);
            tick();
            if (i == 16) begin
                chk("ovf_before", x_ovf, 0);
                chk("ovf_full", x_level, 16);
            end
            if (i == 17) chk("ovf_first_drop", x_ovf, 1);
        end
        sample_valid = 1'b0;
        chk("ovf_level", x_level, 16);
        chk("ovf_head", x_data, 32'h100);
        m_axis_tready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            beat(32'h100 + k);
            tick();
        end
        chk("ovf_drained", x_valid, 0);
        chk("ovf_sticky", x_ovf, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", x_ovf, 0);

        // simultaneous events with FIFO full
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'(32'h200 + i);
            tick();
        end
        chk("sim_full", x_level, 16);
        chk("sim_no_ovf", x_ovf, 0);
        sample_data    = sample_t'(32'h2FF);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("sim_set_wins", x_ovf, 1);
        chk("sim_level16", x_level, 16);
        sample_data   = sample_t'(32'h2FE);
        m_axis_tready = 1'b1;
        beat(32'h200);
        tick();
        sample_valid = 1'b0;
        chk("sim_pushpop_level", x_level, 15);
        chk("sim_pushpop_data", x_data, 32'h201);
        for (int j = 0; j < 16; j++) begin
            beat(32'h201 + j);
            tick();
        end
        chk("sim_drained", x_valid, 0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;

        // framing under random stalls
        sent  = 0;
        beats = 0;
        lasts = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (sent >= 40 && q.size() == 0 && !m_axis_tvalid) break;
            sample_valid = (sent < 40) && (cyc % 2 == 0);
            if (sample_valid) begin
                sample_data = sample_t'(32'h300 + sent);
                q.push_back(32'h300 + sent);
                sent++;
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    chk("frm_extra_beat", x_data, 32'hFFFF);
                end else begin
                    e = q.pop_front();
                    if (m_axis_tlast) lasts++;
                    beat(e);
                end
                beats++;
            end
            tick();
        end
        sample_valid = 1'b0;
        chk("frm_beats", beats, 40);
        chk("frm_lasts", lasts, 10);
        chk("frm_ovf", x_ovf, 0);

        // asynchronous reset mid-frame
        m_axis_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'(32'h3A0 + i);
            tick();
        end
        sample_valid = 1'b0;
        chk("mid_valid", x_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", x_valid, 0);
        chk("arst_data", x_data, 0);
        chk("arst_last", x_last, 0);
        chk("arst_level", x_level, 0);
        chk("arst_ovf", x_ovf, 0);
        tick();
        reset_n = 1'b1;
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'(32'h3B0 + i);
            tick();
        end
        sample_valid  = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            beat(32'h3B0 + k);
            tick();
        end
        chk("post_rst_idle", x_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/read_axi.md
Name: read_axi

Overview:
- Read-side companion of the sample writer.
- Takes the 14-bit sample word and its capture strobe in the clock_50 domain and buffers samples in a small FIFO.
- Drains the FIFO onto an AXI4-Stream master interface toward the DMA/packetiser.
- Frames the stream with tlast every FRAME_LEN beats and flags sample loss when downstream back-pressure overflows the buffer.

Parameters:
- DATA_W, 14: sample width; tdata width.
- DEPTH, 16: FIFO depth in words; power of two, ≥4.
- FRAME_LEN, 256: beats per frame; tlast on last beat; ≥1.

Ports:
- clock_50  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  capture strobe; one sample per high cycle.
- sample_data  in  DATA_W  sample word, qualified by sample_valid.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from downstream.
- m_axis_tlast  out  1  end of frame.
- overflow  out  1  sticky sample-dropped flag.
- clear_overflow  in  1  synchronous clear of overflow.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy; excludes the output register.

Behaviour:
- Reset is asynchronous when reset_n is low. Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - overflow=0, fifo_level=0
  - beat counter=0, FIFO pointers=0
- Reset deasserting mid-frame restarts framing at beat 0. Any in-flight beat is discarded.
- FIFO write:
  - When sample_valid=1 and fifo_level<DEPTH, sample_data is written at the clock edge.
  - When sample_valid=1 and fifo_level==DEPTH, the sample is dropped and overflow is set at that edge. The full check uses the pre-edge level, so a simultaneous pop does not rescue the sample.
- Output stage is a single register, showing data ahead of the handshake.
  - load = FIFO not empty AND (m_axis_tvalid==0 OR m_axis_tready==1).
  - On load: pop the FIFO head into m_axis_tdata and set m_axis_tvalid=1.
  - If the handshake completes and the FIFO is empty: m_axis_tvalid=0.
  - While m_axis_tvalid=1 and m_axis_tready=0, tdata, tvalid and tlast are held stable (AXI rule). tvalid never depends combinationally on tready.
- Latency: sample_valid in cycle N with FIFO and output stage empty gives m_axis_tvalid=1 in cycle N+2, with that sample in tdata.
- Throughput: 1 beat/cycle sustained while tready=1 and the FIFO is not empty.
- fifo_level update: +1 on write, −1 on pop, unchanged when both happen in the same cycle.
- Framing:
  - The beat counter counts completed handshakes (tvalid & tready) from 0 to FRAME_LEN−1, then wraps to 0.
  - m_axis_tlast is registered with the data. It is 1 when the word being loaded is beat FRAME_LEN−1.
  - With FRAME_LEN=1, tlast is always 1.
- Overflow flag:
  - Once set, stays set until clear_overflow=1.
  - If clear_overflow and a drop occur in the same cycle, set wins (overflow stays 1).
  - Overflow does not affect framing; dropped samples simply do not appear.
- FIFO pointers are log2(DEPTH) bits, wrap naturally, with a separate count.

Decomposition:
- Shared package:
  - SAMPLE_W=14 constant
  - default DEPTH and FRAME_LEN constants
  - typedef sample_t logic [SAMPLE_W-1:0]
- One sub-module, sync_fifo_rd: single-clock FIFO with count, full and empty outputs, using the same clock and reset.
- Output register, beat counter and overflow logic stay in read_axi.

Test Plan:
- Reset/latency: release reset, tready=1, one strobe with 0x1ABC in cycle 10 → tvalid=1, tdata=0x1ABC in cycle 12 only; tlast=0; fifo_level returns to 0.
- Back-pressure hold: tready=0, push 0x0001,0x0002,0x0003 → tdata=0x0001 held stable and fifo_level=2; raise tready → beats 1,2,3 on consecutive cycles, then tvalid=0.
- Overflow: DEPTH=16, tready=0, strobe for 20 consecutive cycles → the first 17 samples are retained (16 in FIFO + 1 in output register); overflow=1 from the first drop; after tready=1, exactly 17 beats in order. Pulse clear_overflow → overflow=0.
- Framing: FRAME_LEN=4, continuous strobes, tready toggling randomly → tlast=1 on beats 4, 8, 12, …; a beat count check across stalls shows no missing or duplicated tlast.
- Simultaneous events: strobe in the same cycle as a clear_overflow with the FIFO full → overflow stays 1. With the FIFO full, push and pop in the same cycle → sample dropped and fifo_level=15.
- Reset mid-frame: assert reset_n=0 asynchronously after beat 2 of 4 (tvalid=1) → all outputs 0 immediately. After release, the next frame's tlast lands on its 4th beat.
